// File: rtl/gpio_in_reader_if.sv
// CPU data-bus view of the GPIO input port: address/strobe in, registered read data and irq out.
interface gpio_in_reader_if;
   logic [31:0] Ar;
   logic        MemRead;
   logic [31:0] RDr;
   logic        Irq;

   modport master (output Ar, MemRead, input RDr, Irq);
   modport slave  (input Ar, MemRead, output RDr, Irq);
endinterface

// File: rtl/gpio_in_reader.sv
// GPIO input port: per-pin synchronizer + tick-sampled debounce + sticky rise status,
// read back over the data bus as debounced levels or clear-on-read edge status.
module gpio_in_lane (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   input  logic tick,
   input  logic clr,
   output logic deb,
   output logic stat,
   output logic stat_nxt
);
   logic s1, s2, samp;
   logic deb_nxt, rise;

   // deb only follows s2 when two consecutive ticks saw the same level
   always_comb begin
      deb_nxt = deb;
      if (tick && (s2 == samp)) deb_nxt = s2;
      rise     = deb_nxt & ~deb;
      stat_nxt = (stat & ~clr) | rise;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         samp <= 1'b0;
         deb  <= 1'b0;
         stat <= 1'b0;
      end else begin
         s1   <= pin;
         s2   <= s1;
         if (tick) samp <= s2;
         deb  <= deb_nxt;
         stat <= stat_nxt;
      end
   end
endmodule

module gpio_in_reader #(
   parameter int          WIDTH     = 8,
   parameter int          DB_CYCLES = 4,
   parameter logic [31:0] DATA_ADDR = 32'hABD0,
   parameter logic [31:0] STAT_ADDR = 32'hABD4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Inr,
   gpio_in_reader_if.slave  bus
);
   localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [CW-1:0]    cnt;
   logic             tick;
   logic             rd_data, rd_stat;
   logic [WIDTH-1:0] deb, stat, stat_nxt;

   assign tick    = (cnt == CNT_LAST);
   assign rd_data = bus.MemRead && (bus.Ar == DATA_ADDR);
   assign rd_stat = bus.MemRead && (bus.Ar == STAT_ADDR);

   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= tick ? '0 : cnt + 1'b1;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      gpio_in_lane u_lane (
         .clk      (clk),
         .rst      (rst),
         .pin      (Inr[i]),
         .tick     (tick),
         .clr      (rd_stat),
         .deb      (deb[i]),
         .stat     (stat[i]),
         .stat_nxt (stat_nxt[i])
      );
   end

   // Irq registered from next-state status so it tracks stat exactly, with no path from the bus
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.RDr <= '0;
         bus.Irq <= 1'b0;
      end else begin
         bus.Irq <= |stat_nxt;
         if (rd_data)      bus.RDr <= 32'(deb);
         else if (rd_stat) bus.RDr <= 32'(stat);
         else              bus.RDr <= '0;
      end
   end
endmodule

// File: tb/tb_gpio_in_reader.sv
// Directed bench for gpio_in_reader (WIDTH=8, DB_CYCLES=4); expectations hand-computed.
module tb_gpio_in_reader;
   localparam logic [31:0] DA = 32'hABD0;
   localparam logic [31:0] SA = 32'hABD4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] Inr = 8'h00;
   int         nchk = 0;
   int         nerr = 0;
   int         ecnt = 0;

   gpio_in_reader_if bus_if ();

   gpio_in_reader #(.WIDTH(8), .DB_CYCLES(4), .DATA_ADDR(DA), .STAT_ADDR(SA)) dut (
      .clk (clk),
      .rst (rst),
      .Inr (Inr),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         ecnt++;
      end
   endtask

   // one bus cycle; on return RDr holds its response
   task automatic bus_cyc(input logic [31:0] a, input logic mr);
      bus_if.Ar      = a;
      bus_if.MemRead = mr;
      cyc(1);
      bus_if.Ar      = '0;
      bus_if.MemRead = 1'b0;
   endtask

   initial begin
      bus_if.Ar      = '0;
      bus_if.MemRead = 1'b0;

      // 1: reset with pins high
      Inr = 8'hFF;
      cyc(3);
      chk("rst_rdr", bus_if.RDr, 32'h0);
      chk("rst_irq", {31'b0, bus_if.Irq}, 32'h0);
      bus_cyc(DA, 1'b1);
      chk("rst_rd_data", bus_if.RDr, 32'h0);
      bus_cyc(SA, 1'b1);
      chk("rst_rd_stat", bus_if.RDr, 32'h0);
      chk("rst_irq2", {31'b0, bus_if.Irq}, 32'h0);
      rst = 1'b0;
      ecnt = 0;
      cyc(9);
      chk("t1_irq", {31'b0, bus_if.Irq}, 32'h1);
      bus_cyc(DA, 1'b1);
      chk("t1_data", bus_if.RDr, 32'h000000FF);
      cyc(1);
      chk("t1_rdr_idle", bus_if.RDr, 32'h0);
      bus_cyc(SA, 1'b1);
      chk("t1_stat", bus_if.RDr, 32'h000000FF);
      chk("t1_irq_clr", {31'b0, bus_if.Irq}, 32'h0);

      // 2: glitch rejection then qualified rise
      Inr = 8'h00;
      cyc(12);
      chk("t2_irq_fall", {31'b0, bus_if.Irq}, 32'h0);
      bus_cyc(DA, 1'b1);
      chk("t2_data0", bus_if.RDr, 32'h0);
      Inr = 8'h01;
      cyc(4);
      Inr = 8'h00;
      cyc(12);
      chk("t2_glitch_irq", {31'b0, bus_if.Irq}, 32'h0);
      bus_cyc(DA, 1'b1);
      chk("t2_glitch_data", bus_if.RDr, 32'h0);
      bus_cyc(SA, 1'b1);
      chk("t2_glitch_stat", bus_if.RDr, 32'h0);
      Inr = 8'h01;
      cyc(12);
      chk("t2_irq", {31'b0, bus_if.Irq}, 32'h1);
      bus_cyc(DA, 1'b1);
      chk("t2_data", bus_if.RDr, 32'h1);
      bus_cyc(SA, 1'b1);
      chk("t2_stat", bus_if.RDr, 32'h1);

      // 3: clear-on-read with stat=05
      Inr = 8'h00;
      cyc(12);
      Inr = 8'h05;
      cyc(12);
      chk("t3_irq_set", {31'b0, bus_if.Irq}, 32'h1);
      bus_cyc(SA, 1'b1);
      chk("t3_stat", bus_if.RDr, 32'h5);
      chk("t3_irq_clr", {31'b0, bus_if.Irq}, 32'h0);
      bus_cyc(SA, 1'b1);
      chk("t3_stat2", bus_if.RDr, 32'h0);

      // 4: bit2 rise lands on the same edge as a status read of 01
      Inr = 8'h00;
      cyc(12);
      Inr = 8'h01;
      cyc(12);
      while ((ecnt % 4) != 0) cyc(1);
      Inr = 8'h05;
      cyc(7);
      bus_cyc(SA, 1'b1);
      chk("t4_stat", bus_if.RDr, 32'h1);
      chk("t4_irq", {31'b0, bus_if.Irq}, 32'h1);
      bus_cyc(SA, 1'b1);
      chk("t4_stat_after", bus_if.RDr, 32'h4);

      // 5: decode misses leave stat alone
      Inr = 8'h00;
      cyc(12);
      Inr = 8'h08;
      cyc(12);
      bus_cyc(DA, 1'b0);
      chk("t5_nomr", bus_if.RDr, 32'h0);
      bus_cyc(SA, 1'b0);
      chk("t5_nomr_stat", bus_if.RDr, 32'h0);
      bus_cyc(32'hABCD, 1'b1);
      chk("t5_abcd", bus_if.RDr, 32'h0);
      bus_cyc(32'h0001ABD4, 1'b1);
      chk("t5_hiaddr", bus_if.RDr, 32'h0);
      chk("t5_irq", {31'b0, bus_if.Irq}, 32'h1);
      bus_cyc(DA, 1'b1);
      chk("t5_data", bus_if.RDr, 32'h8);
      bus_cyc(SA, 1'b1);
      chk("t5_stat", bus_if.RDr, 32'h8);

      // 6: falling edge is not recorded
      Inr = 8'h00;
      cyc(12);
      bus_cyc(DA, 1'b1);
      chk("t6_data", bus_if.RDr, 32'h0);
      bus_cyc(SA, 1'b1);
      chk("t6_stat", bus_if.RDr, 32'h0);
      chk("t6_irq", {31'b0, bus_if.Irq}, 32'h0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/gpio_in_reader.md
Name: gpio_in_reader

Overview:
- Memory-mapped GPIO input port: the read-side counterpart of the CPU's GPIO write port.
- Synchronizes and debounces external input pins.
- Records sticky rising-edge events and returns either the debounced pin data or the edge status to the CPU on a memory read.
- Sits on the data-memory bus beside data RAM and the GPIO output register; the CPU's read-data mux selects RDr for its addresses.

Parameters:
WIDTH, 8, number of input pins (1..32); read data zero-extended to 32 bits
DB_CYCLES, 4, debounce sample period in clk cycles (>=1)
DATA_ADDR, 32'hABD0, address returning debounced pin levels
STAT_ADDR, 32'hABD4, address returning sticky rising-edge status (clear-on-read)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
Ar  input  32  CPU data address
MemRead  input  1  CPU memory-read strobe
Inr  input  WIDTH  external pins, asynchronous to clk
RDr  output  32  registered read data
Irq  output  1  high while any status bit is set

Behaviour:
- Reset, synchronous and active-high, is sampled on the clk rising edge. It clears all of the following to 0, and overrides all other activity in that cycle:
  - synchronizer flops s1 and s2
  - tick counter
  - sample register samp
  - debounced register deb
  - status register stat
  - RDr and Irq
- Synchronizer: s1<=Inr; s2<=s1. No other logic reads Inr.
- Tick counter:
  - counts 0..DB_CYCLES-1 and wraps to 0
  - tick=1 in the cycle where count==DB_CYCLES-1
  - with DB_CYCLES=1, tick=1 every cycle
- Debounce, on a tick only:
  - samp<=s2
  - for each bit i with s2[i]==samp[i], deb[i]<=s2[i]; other bits hold.
  - A deb bit therefore changes only after two consecutive ticks agree.
  - Latency from an Inr change to deb: DB_CYCLES+2 to 2*DB_CYCLES+1 edges.
  - Any level lasting <=DB_CYCLES cycles never reaches deb.
- Edge detect:
  - rise = deb_next & ~deb, where deb_next is the value being loaded this cycle.
  - stat <= (stat & ~clr) | rise.
  - clr is all-ones in a cycle where a status read is accepted, otherwise zero.
  - A rise coinciding with a clear leaves that bit set (set wins).
  - Falling edges are not recorded.
- Read decode:
  - A read is accepted when MemRead=1 and Ar equals DATA_ADDR or STAT_ADDR exactly (full 32-bit compare).
  - Ar==DATA_ADDR: RDr<={zeros, deb}, using the pre-update deb of that cycle.
  - Ar==STAT_ADDR: RDr<={zeros, stat}, using the pre-clear value; stat clears at the same edge.
  - MemRead=1 with any other Ar: RDr<=0, no side effects.
  - MemRead=0: RDr<=0, no side effects, even if Ar matches a mapped address.
- Read latency: exactly 1 cycle. RDr is valid the cycle after the MemRead cycle and is 0 otherwise.
- Back-to-back reads: each cycle is independent. Two consecutive STAT_ADDR reads return the captured status, then only edges that arrived in between.
- Irq = |stat. It is driven from a register with no combinational path from Inr, Ar or MemRead.
- Reset mid-debounce: any partially qualified change is discarded, so deb=0 after reset. A pin held high through reset produces a rise event after re-qualification.

Test Plan:
1. Reset, with Inr=8'hFF held → RDr, Irq, deb and stat all 0 in the cycle after rst. After rst deasserts, with Inr still 8'hFF, deb reaches 8'hFF within 9 edges (DB_CYCLES=4); a DATA_ADDR read then returns 32'h000000FF, and stat=8'hFF with Irq=1.
2. Glitch rejection: from Inr=0, pulse bit0 high for 4 cycles → deb stays 0, stat stays 0, Irq stays 0. Then hold bit0 high for 12 cycles → deb[0]=1, and a STAT_ADDR read returns 32'h1.
3. Clear-on-read: with stat=8'h05, read STAT_ADDR → RDr=32'h5 the next cycle, stat=0, Irq=0. An immediate second STAT_ADDR read → RDr=0.
4. Simultaneous set and clear: time a bit2 rise into the same cycle as a STAT_ADDR read of stat=8'h01 → RDr=32'h1 and stat=8'h04 afterwards, with Irq still 1.
5. Decode: Ar=32'hABD0 with MemRead=0 → RDr=0 and no state change. Ar=32'hABCD or 32'h0001ABD4 with MemRead=1 → RDr=0 and stat unchanged.
6. Falling edge: with deb=8'h08, drop bit3 and let it qualify → a DATA_ADDR read returns 0, and a STAT_ADDR read returns 0 with no new event.
